gpio_in_conditioner: RTL and testbench

- Fabric-side input stage directly upstream of the MSS subsystem GPIO_IN[31:0] bus.
- Takes raw, asynchronous board pad inputs and synchronises them into the fabric clock domain.
- Debounces each bit with a shared-prescaler sample tick, then drives clean, stable levels to the MSS GPIO_IN.
- Optionally captures per-bit edge events into sticky pending flags and raises a fabric interrupt.

---
 rtl/gpio_in_conditioner.sv | 109 ++++++++++
 tb/tb_gpio_in_conditioner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_conditioner.sv
// Pad input conditioner: per-bit synchroniser, tick-paced debounce, stable levels for MSS GPIO_IN.
// Define GPIO_COND_EDGE_IRQ_EN to build edge capture, sticky EDGE_PEND flags and IRQ.
module gpio_in_conditioner #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      TICK_DIV    = 1000,
   parameter int unsigned      DB_COUNT    = 4,
   parameter logic [WIDTH-1:0] STABLE_INIT = '0
) (
   input  logic             FAB_CCC_GL0,
   input  logic             FAB_RESET_N,
   input  logic [WIDTH-1:0] PAD_IN,
   output logic [WIDTH-1:0] GPIO_IN,
   input  logic [WIDTH-1:0] RISE_EN,
   input  logic [WIDTH-1:0] FALL_EN,
   input  logic [WIDTH-1:0] EDGE_CLR,
   output logic [WIDTH-1:0] EDGE_PEND,
   output logic             IRQ
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DB_LAST   = CW'(DB_COUNT - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [PW-1:0]    pre_q, pre_d;
   logic             tick;
   logic [WIDTH-1:0] gpio_q, gpio_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
      if (!FAB_RESET_N) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= STABLE_INIT;
      end else begin
         sync_q[0] <= PAD_IN;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // With TICK_DIV=1 the count is pinned at 0, so the tick fires every cycle.
   assign tick  = (pre_q == TICK_LAST);
   assign pre_d = tick ? '0 : pre_q + PW'(1);

   always_comb begin
      gpio_d = gpio_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (sync[i] == gpio_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
               gpio_d[i] = sync[i];
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
      if (!FAB_RESET_N) begin
         pre_q  <= '0;
         gpio_q <= STABLE_INIT;
         for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         pre_q  <= pre_d;
         gpio_q <= gpio_d;
         for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign GPIO_IN = gpio_q;

`ifdef GPIO_COND_EDGE_IRQ_EN
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] rise, fall;

   // prev_q resets to the same value as gpio_q, so reset release never looks like an edge.
   assign rise   = gpio_q & ~prev_q;
   assign fall   = ~gpio_q & prev_q;
   assign pend_d = (pend_q & ~EDGE_CLR) | (rise & RISE_EN) | (fall & FALL_EN);

   always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
      if (!FAB_RESET_N) begin
         prev_q <= STABLE_INIT;
         pend_q <= '0;
      end else begin
         prev_q <= gpio_q;
         pend_q <= pend_d;
      end
   end

   assign EDGE_PEND = pend_q;
   assign IRQ       = |pend_q;
`else
   logic unused_edge_inputs;
   assign unused_edge_inputs = ^{RISE_EN, FALL_EN, EDGE_CLR};
   assign EDGE_PEND = '0;
   assign IRQ       = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner: a TICK_DIV=1 instance for latency/glitch/edge
// behaviour and a TICK_DIV=1000 instance for tick pacing.
module tb_gpio_in_conditioner;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] pad_f, pad_s, gpio_f, gpio_s, pend_f, pend_s;
   logic [W-1:0] rise_en, fall_en, clr;
   logic         irq_f, irq_s;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   gpio_in_conditioner #(.WIDTH(W), .SYNC_STAGES(2), .TICK_DIV(1), .DB_COUNT(4),
                         .STABLE_INIT('0)) u_fast (
      .FAB_CCC_GL0(clk), .FAB_RESET_N(rst_n), .PAD_IN(pad_f), .GPIO_IN(gpio_f),
      .RISE_EN(rise_en), .FALL_EN(fall_en), .EDGE_CLR(clr),
      .EDGE_PEND(pend_f), .IRQ(irq_f));

   gpio_in_conditioner #(.WIDTH(W), .SYNC_STAGES(2), .TICK_DIV(1000), .DB_COUNT(4),
                         .STABLE_INIT('0)) u_slow (
      .FAB_CCC_GL0(clk), .FAB_RESET_N(rst_n), .PAD_IN(pad_s), .GPIO_IN(gpio_s),
      .RISE_EN('0), .FALL_EN('0), .EDGE_CLR('0),
      .EDGE_PEND(pend_s), .IRQ(irq_s));

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      pad_f = '1;
      pad_s = '1;
      wait_edges(3);
      checks++; if (gpio_f !== 32'h0) begin errors++; $display("FAIL rst_gpio_f got=%h exp=%h", gpio_f, 32'h0); end
      checks++; if (gpio_s !== 32'h0) begin errors++; $display("FAIL rst_gpio_s got=%h exp=%h", gpio_s, 32'h0); end
      checks++; if (pend_f !== 32'h0) begin errors++; $display("FAIL rst_pend got=%h exp=%h", pend_f, 32'h0); end
      checks++; if (irq_f !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq_f); end
      @(negedge clk);
      pad_f = '0;
      pad_s = '0;
      wait_edges(2);
      @(negedge clk);
      rst_n = 1'b1;
      wait_edges(10);
      checks++; if (gpio_f !== 32'h0) begin errors++; $display("FAIL rel_gpio got=%h exp=%h", gpio_f, 32'h0); end
      checks++; if (irq_f !== 1'b0) begin errors++; $display("FAIL rel_irq got=%b exp=0", irq_f); end
      checks++; if (pend_f !== 32'h0) begin errors++; $display("FAIL rel_pend got=%h exp=%h", pend_f, 32'h0); end
   endtask

   task automatic test_clean_change;
      logic exp;
      @(negedge clk);
      pad_f[0] = 1'b1;
      for (int j = 0; j < 6; j++) begin
         wait_edges(1);
         exp = (j == 5);
         checks++;
         if (gpio_f[0] !== exp) begin
            errors++; $display("FAIL latency_k+%0d got=%b exp=%b", j, gpio_f[0], exp);
         end
      end
      @(negedge clk);
      pad_f[0] = 1'b0;
      wait_edges(8);
      checks++; if (gpio_f !== 32'h0) begin errors++; $display("FAIL clean_return got=%h exp=%h", gpio_f, 32'h0); end
   endtask

   task automatic test_glitch;
      @(negedge clk);
      pad_f[5] = 1'b1;
      wait_edges(3);
      @(negedge clk);
      pad_f[5] = 1'b0;
      wait_edges(10);
      checks++; if (gpio_f[5] !== 1'b0) begin errors++; $display("FAIL glitch_reject got=%b exp=0", gpio_f[5]); end
      // A fresh pulse must take the full latency, showing the counter restarted from 0.
      @(negedge clk);
      pad_f[5] = 1'b1;
      wait_edges(5);
      checks++; if (gpio_f[5] !== 1'b0) begin errors++; $display("FAIL pulse_early got=%b exp=0", gpio_f[5]); end
      wait_edges(1);
      checks++; if (gpio_f[5] !== 1'b1) begin errors++; $display("FAIL pulse_accept got=%b exp=1", gpio_f[5]); end
      wait_edges(4);
      @(negedge clk);
      pad_f[5] = 1'b0;
      wait_edges(8);
      checks++; if (gpio_f !== 32'h0) begin errors++; $display("FAIL pulse_return got=%h exp=%h", gpio_f, 32'h0); end
   endtask

   task automatic test_multi_bit;
      @(negedge clk);
      pad_f = 32'h8001_0F0E;
      wait_edges(5);
      checks++; if (gpio_f !== 32'h0) begin errors++; $display("FAIL multi_early got=%h exp=%h", gpio_f, 32'h0); end
      wait_edges(1);
      checks++; if (gpio_f !== 32'h8001_0F0E) begin errors++; $display("FAIL multi_set got=%h exp=%h", gpio_f, 32'h8001_0F0E); end
      @(negedge clk);
      pad_f = 32'h0001_0000;
      wait_edges(6);
      checks++; if (gpio_f !== 32'h0001_0000) begin errors++; $display("FAIL multi_clr got=%h exp=%h", gpio_f, 32'h0001_0000); end
      @(negedge clk);
      pad_f = '0;
      wait_edges(8);
      checks++; if (gpio_f !== 32'h0) begin errors++; $display("FAIL multi_return got=%h exp=%h", gpio_f, 32'h0); end
   endtask

   task automatic test_tick_pacing;
      int n;
      bit found;
      n = 0;
      found = 1'b0;
      @(negedge clk);
      pad_s[31] = 1'b1;
      while (!found && n < 6000) begin
         wait_edges(1);
         n++;
         if (gpio_s[31] === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || n < 3003 || n > 4002) begin
         errors++; $display("FAIL tick_latency got=%0d edges (found=%0b) exp=3003..4002", n, found);
      end
      if (found) begin
         // Now at tick edge E; ticks recur at E+1000*j. Bounce high across E+3000.
         @(negedge clk);
         pad_s[31] = 1'b0;
         wait_edges(2989);
         @(negedge clk);
         pad_s[31] = 1'b1;
         wait_edges(20);
         @(negedge clk);
         pad_s[31] = 1'b0;
         wait_edges(996);
         checks++; if (gpio_s[31] !== 1'b1) begin errors++; $display("FAIL bounce_E+4005 got=%b exp=1", gpio_s[31]); end
         wait_edges(2994);
         checks++; if (gpio_s[31] !== 1'b1) begin errors++; $display("FAIL bounce_E+6999 got=%b exp=1", gpio_s[31]); end
         wait_edges(1);
         checks++; if (gpio_s[31] !== 1'b0) begin errors++; $display("FAIL bounce_E+7000 got=%b exp=0", gpio_s[31]); end
      end
   endtask

`ifdef GPIO_COND_EDGE_IRQ_EN
   task automatic test_edge_irq;
      rise_en = 32'h1;
      fall_en = 32'h0;
      @(negedge clk);
      pad_f[0] = 1'b1;
      wait_edges(6);
      checks++; if (pend_f !== 32'h0) begin errors++; $display("FAIL pend_lag got=%h exp=%h", pend_f, 32'h0); end
      wait_edges(1);
      checks++; if (pend_f !== 32'h1) begin errors++; $display("FAIL pend_rise got=%h exp=%h", pend_f, 32'h1); end
      checks++; if (irq_f !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq_f); end
      wait_edges(3);
      checks++; if (pend_f !== 32'h1) begin errors++; $display("FAIL pend_sticky got=%h exp=%h", pend_f, 32'h1); end
      @(negedge clk);
      clr = 32'h1;
      wait_edges(1);
      checks++; if (pend_f !== 32'h0) begin errors++; $display("FAIL pend_clr got=%h exp=%h", pend_f, 32'h0); end
      checks++; if (irq_f !== 1'b0) begin errors++; $display("FAIL irq_clr got=%b exp=0", irq_f); end
      @(negedge clk);
      clr = '0;
      pad_f[0] = 1'b0;
      wait_edges(10);
      checks++; if (pend_f !== 32'h0) begin errors++; $display("FAIL pend_no_fall got=%h exp=%h", pend_f, 32'h0); end
      @(negedge clk);
      pad_f[0] = 1'b1;
      wait_edges(6);
      @(negedge clk);
      clr = 32'h1;
      wait_edges(1);
      checks++; if (pend_f !== 32'h1) begin errors++; $display("FAIL set_wins got=%h exp=%h", pend_f, 32'h1); end
      @(negedge clk);
      clr = '0;
      wait_edges(1);
      checks++; if (pend_f !== 32'h1) begin errors++; $display("FAIL set_hold got=%h exp=%h", pend_f, 32'h1); end
      @(negedge clk);
      rise_en = '0;
      fall_en = 32'h1;
      clr = 32'h1;
      @(negedge clk);
      clr = '0;
      pad_f[0] = 1'b0;
      wait_edges(8);
      checks++; if (pend_f !== 32'h1) begin errors++; $display("FAIL pend_fall got=%h exp=%h", pend_f, 32'h1); end
      @(negedge clk);
      fall_en = '0;
      clr = '1;
      @(negedge clk);
      clr = '0;
      wait_edges(1);
      checks++; if (irq_f !== 1'b0) begin errors++; $display("FAIL irq_final got=%b exp=0", irq_f); end
   endtask
`else
   task automatic test_edge_irq;
      rise_en = '1;
      fall_en = '1;
      @(negedge clk);
      pad_f[0] = 1'b1;
      wait_edges(10);
      @(negedge clk);
      pad_f[0] = 1'b0;
      wait_edges(10);
      checks++; if (pend_f !== 32'h0) begin errors++; $display("FAIL pend_tied got=%h exp=%h", pend_f, 32'h0); end
      checks++; if (irq_f !== 1'b0) begin errors++; $display("FAIL irq_tied got=%b exp=0", irq_f); end
      rise_en = '0;
      fall_en = '0;
   endtask
`endif

   task automatic test_reset_mid;
      @(negedge clk);
      pad_f[3] = 1'b1;
      wait_edges(4);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (gpio_f !== 32'h0) begin errors++; $display("FAIL midrst_gpio got=%h exp=%h", gpio_f, 32'h0); end
      wait_edges(2);
      @(negedge clk);
      rst_n = 1'b1;
      wait_edges(5);
      checks++; if (gpio_f[3] !== 1'b0) begin errors++; $display("FAIL midrst_early got=%b exp=0", gpio_f[3]); end
      wait_edges(1);
      checks++; if (gpio_f[3] !== 1'b1) begin errors++; $display("FAIL midrst_accept got=%b exp=1", gpio_f[3]); end
   endtask

   initial begin
      pad_f   = '0;
      pad_s   = '0;
      rise_en = '0;
      fall_en = '0;
      clr     = '0;
      test_reset();
      test_clean_change();
      test_glitch();
      test_multi_bit();
      test_edge_irq();
      test_tick_pacing();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
